bias_add_stage: RTL and testbench

- Pipelined bias-add stage that consumes the packed constant bias bus from a layer's BIAS bank and the N parallel lane sums from the adder trees.
- Adds each lane's bias, saturates the result to 18-bit signed, and optionally applies ReLU.
- Sits between the adder-tree outputs and the next layer's activation buffer.
- Uses a valid/ready stream on both sides with full backpressure, and counts output beats to mark the end of each frame.

---
 rtl/bias_add_stage_if.sv | 28 ++
 rtl/bias_add_stage.sv | 111 +++++++++++
 tb/tb_bias_add_stage.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_add_stage_if.sv
// rtl/bias_add_stage_if.sv - stream and bias bus bundle for bias_add_stage
interface bias_add_stage_if #(
  parameter int N_adder_tree = 16,
  parameter int ACC_W        = 24,
  parameter int OUT_W        = 18
);
  logic [N_adder_tree*18-1:0]    bias_q;
  logic [N_adder_tree*ACC_W-1:0] in_data;
  logic                          in_valid;
  logic                          in_ready;
  logic [N_adder_tree*OUT_W-1:0] out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_last;
  logic [N_adder_tree-1:0]       sat_flag;

  // Producer/consumer side (adder trees, bias bank and downstream buffer)
  modport master (
    output bias_q, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, sat_flag
  );

  // Bias-add stage side
  modport slave (
    input  bias_q, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, sat_flag
  );
endinterface

// File: rtl/bias_add_stage.sv
// rtl/bias_add_stage.sv - two-stage bias add, saturate to OUT_W, optional ReLU (BIAS_ADD_RELU_EN)
module bias_add_stage #(
  parameter int N_adder_tree  = 16,
  parameter int ACC_W         = 24,
  parameter int OUT_W         = 18,
  parameter int PIX_PER_FRAME = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  bias_add_stage_if.slave   bus
);
  localparam int BIAS_W = 18;
  localparam int SUM_W  = ACC_W + 1;
  localparam int CNT_W  = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIX_PER_FRAME - 1);

  // Clip limits expressed at the full sum width so the compare is exact
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                              adv1;
  logic                              adv2;
  logic                              s1_valid;
  logic [N_adder_tree-1:0][SUM_W-1:0] s1_sum;
  logic [N_adder_tree-1:0][SUM_W-1:0] sum_next;
  logic                              s2_valid;
  logic [N_adder_tree*OUT_W-1:0]     s2_data;
  logic [N_adder_tree-1:0]           s2_sat;
  logic [N_adder_tree*OUT_W-1:0]     sat_data;
  logic [N_adder_tree-1:0]           sat_hit;
  logic [CNT_W-1:0]                  cnt;

  // S2 moves when empty or drained; S1 moves when empty or S2 moves
  assign adv2 = !s2_valid || bus.out_ready;
  assign adv1 = !s1_valid || adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.sat_flag  = s2_sat;
  assign bus.out_last  = s2_valid && (cnt == LAST_CNT);

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    logic signed [SUM_W-1:0] lane_in;
    logic signed [SUM_W-1:0] lane_bias;
    logic signed [SUM_W-1:0] lane_sum;
    logic [OUT_W-1:0]        lane_clip;
    logic                    lane_hi;
    logic                    lane_lo;

    // One guard bit above ACC_W is enough: the bias is never wider than the lane sum
    assign lane_in   = {bus.in_data[ACC_W*i+ACC_W-1], bus.in_data[ACC_W*i +: ACC_W]};
    assign lane_bias = {{(SUM_W-BIAS_W){bus.bias_q[BIAS_W*i+BIAS_W-1]}}, bus.bias_q[BIAS_W*i +: BIAS_W]};
    assign sum_next[i] = lane_in + lane_bias;

    assign lane_sum  = s1_sum[i];
    assign lane_hi   = lane_sum > SAT_MAX;
    assign lane_lo   = lane_sum < SAT_MIN;
    assign lane_clip = lane_hi ? SAT_MAX[OUT_W-1:0] :
                       lane_lo ? SAT_MIN[OUT_W-1:0] : lane_sum[OUT_W-1:0];
    assign sat_hit[i] = lane_hi || lane_lo;

`ifdef BIAS_ADD_RELU_EN
    // ReLU after the clip; the flag keeps reporting the clip itself
    assign sat_data[OUT_W*i +: OUT_W] = lane_clip[OUT_W-1] ? '0 : lane_clip;
`else
    assign sat_data[OUT_W*i +: OUT_W] = lane_clip;
`endif
  end

  // S1: register the full-width biased sums on an input-side advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sum <= sum_next;
      end
    end
  end

  // S2: register clipped lanes and flags; held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sat   <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= sat_data;
        s2_sat  <= sat_hit;
      end
    end
  end

  // Frame position: counts output handshakes, wraps at the last beat of a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (s2_valid && bus.out_ready) begin
      if (cnt == LAST_CNT) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bias_add_stage.sv
// tb/tb_bias_add_stage.sv - directed self-checking bench for bias_add_stage
`timescale 1ns/1ps
module tb_bias_add_stage;
  localparam int N     = 16;
  localparam int ACC_W = 24;
  localparam int OUT_W = 18;
  localparam int PIX   = 4;
  localparam int DW    = N*OUT_W;
`ifdef BIAS_ADD_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bias_add_stage_if #(.N_adder_tree(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  bias_add_stage #(.N_adder_tree(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .PIX_PER_FRAME(PIX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int seq_in = 0;
  int fpos = 0;
  int expq[$];
  bit m_s1 = 1'b0;
  bit m_s2 = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] put_out(input logic [DW-1:0] v, input int i, input int x);
    logic [OUT_W-1:0] t;
    t = OUT_W'(x);
    if (RELU && x < 0) t = '0;
    v[i*OUT_W +: OUT_W] = t;
    return v;
  endfunction

  task automatic set_lane(input int i, input int din, input int b);
    bus.in_data[i*ACC_W +: ACC_W] = ACC_W'(din);
    bus.bias_q[i*18 +: 18] = 18'(b);
  endtask

  // Stream beat s: lane0 = s*100+1 with bias 5, lane15 = -s*1000 with bias -3
  task automatic set_beat(input int s);
    bus.in_data = '0;
    bus.bias_q = '0;
    set_lane(0, s*100 + 1, 5);
    set_lane(15, -(s*1000), -3);
  endtask

  function automatic logic [DW-1:0] exp_beat(input int s);
    logic [DW-1:0] e;
    e = '0;
    e = put_out(e, 0, s*100 + 6);
    e = put_out(e, 15, -(s*1000) - 3);
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = '0;
    bus.bias_q = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fpos = 0;
    expq.delete();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
  endtask

  task automatic run_beats(input int nb, input bit toggle);
    int sent;
    int recv;
    int cyc;
    int s;
    bit prev_stall;
    bit adv1;
    bit adv2;
    logic [DW-1:0] prev_data;
    logic [N-1:0] prev_sat;
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0;
    prev_data = '0; prev_sat = '0;
    while (recv < nb && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      bus.in_valid = (sent < nb);
      if (sent < nb) set_beat(seq_in);
      #1;
      check("out_valid", DW'(bus.out_valid), DW'(m_s2));
      check("in_ready", DW'(bus.in_ready), DW'(!(m_s1 && m_s2 && !bus.out_ready)));
      if (prev_stall) begin
        check("stall_data_hold", bus.out_data, prev_data);
        check("stall_sat_hold", DW'(bus.sat_flag), DW'(prev_sat));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          check("spurious_beat", DW'(1), DW'(0));
        end else begin
          s = expq.pop_front();
          check("beat_data", bus.out_data, exp_beat(s));
          check("out_last", DW'(bus.out_last), DW'(fpos == PIX-1));
          fpos = (fpos + 1) % PIX;
        end
        recv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(seq_in);
        seq_in++;
        sent++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_sat = bus.sat_flag;
      adv2 = !m_s2 || bus.out_ready;
      adv1 = !m_s1 || adv2;
      if (adv2) m_s2 = m_s1;
      if (adv1) m_s1 = bus.in_valid;
      cyc++;
    end
    check("beats_done", DW'(recv), DW'(nb));
    bus.in_valid = 1'b0;
  endtask

  // Single beat with an exact two-cycle latency check
  task automatic one_beat();
    @(negedge clk);
    set_beat(seq_in);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    #1 check("lat_in_ready", DW'(bus.in_ready), DW'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("lat_cycle1", DW'(bus.out_valid), DW'(0));
    @(negedge clk);
    #1 check("lat_cycle2", DW'(bus.out_valid), DW'(1));
    check("lat_data", bus.out_data, exp_beat(seq_in));
    check("lat_last", DW'(bus.out_last), DW'(fpos == PIX-1));
    fpos = (fpos + 1) % PIX;
    seq_in++;
  endtask

  logic [DW-1:0] e;

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = '0;
    bus.bias_q = '0;

    // reset state
    @(negedge clk);
    #1;
    check("rst_out_valid", DW'(bus.out_valid), DW'(0));
    check("rst_in_ready", DW'(bus.in_ready), DW'(1));
    check("rst_out_data", bus.out_data, DW'(0));
    check("rst_sat_flag", DW'(bus.sat_flag), DW'(0));
    check("rst_out_last", DW'(bus.out_last), DW'(0));
    check("rst_cnt", DW'(dut.cnt), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("idle_out_valid", DW'(bus.out_valid), DW'(0));

    // arithmetic and saturation boundaries
    @(negedge clk);
    bus.in_data = '0;
    bus.bias_q = '0;
    set_lane(0, 1000, -13784);
    set_lane(1, 0, 7);
    set_lane(2, -5, 0);
    set_lane(3, 200000, 5000);
    set_lane(4, -200000, -1);
    set_lane(5, 131070, 1);
    set_lane(6, -131072, 0);
    set_lane(7, -131073, 0);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("vec_cycle1_valid", DW'(bus.out_valid), DW'(0));
    @(negedge clk);
    #1 check("vec_cycle2_valid", DW'(bus.out_valid), DW'(1));
    e = '0;
    e = put_out(e, 0, -12784);
    e = put_out(e, 1, 7);
    e = put_out(e, 2, -5);
    e = put_out(e, 3, 131071);
    e = put_out(e, 4, -131072);
    e = put_out(e, 5, 131071);
    e = put_out(e, 6, -131072);
    e = put_out(e, 7, -131072);
    check("vec_data", bus.out_data, e);
    check("vec_sat", DW'(bus.sat_flag), DW'(16'h0098));
    check("vec_last", DW'(bus.out_last), DW'(0));
    @(negedge clk);
    #1 check("vec_drained", DW'(bus.out_valid), DW'(0));

    // 8 beats under 1,0,0,1 backpressure
    do_reset();
    run_beats(8, 1'b1);

    // frame marking with continuous flow
    do_reset();
    run_beats(9, 1'b0);
    @(negedge clk);
    #1 check("cnt_after_9", DW'(dut.cnt), DW'(1));

    // async reset with both stages full
    do_reset();
    @(negedge clk);
    set_beat(seq_in);
    bus.in_valid = 1'b1;
    @(negedge clk);
    set_beat(seq_in + 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("full_in_ready", DW'(bus.in_ready), DW'(0));
    check("full_out_valid", DW'(bus.out_valid), DW'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", DW'(bus.out_valid), DW'(0));
    check("async_in_ready", DW'(bus.in_ready), DW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    fpos = 0;
    expq.delete();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    seq_in = seq_in + 2;
    one_beat();
    run_beats(3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
